exp_scale_reduce: RTL and testbench



---
 rtl/exp_scale_pkg.sv | 27 ++
 rtl/seq_udiv_restoring.sv | 79 +++++++
 rtl/exp_scale_reduce.sv | 160 ++++++++++++++++
 tb/tb_exp_scale_reduce.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exp_scale_pkg.sv
// ----------------------------------------------------------------------------
// exp_scale_pkg
// Shared definitions for the exp-scale table. Both the forward exp-scale lookup
// and the inverse range reducer use this table, so the two ends stay consistent.
//   ES_DATA_W / ES_FRAC_W : Q4.8 word geometry
//   EXP_SCALE_0..3        : scale table entries in Q4.8
//   es_state_t            : FSM states of exp_scale_reduce
// ----------------------------------------------------------------------------
package exp_scale_pkg;

    localparam int ES_DATA_W = 12;
    localparam int ES_FRAC_W = 8;

    localparam logic [ES_DATA_W-1:0] EXP_SCALE_0 = 12'h100;
    localparam logic [ES_DATA_W-1:0] EXP_SCALE_1 = 12'h2B8;
    localparam logic [ES_DATA_W-1:0] EXP_SCALE_2 = 12'h764;
    // Saturated entry: every input at or above it maps to k=3
    localparam logic [ES_DATA_W-1:0] EXP_SCALE_3 = 12'h7FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DIV,
        ST_DONE
    } es_state_t;

endpackage

// File: rtl/seq_udiv_restoring.sv
// ----------------------------------------------------------------------------
// seq_udiv_restoring
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// The top DVD_W-ITERS dividend bits are preloaded into the remainder, so the
// caller must guarantee they are smaller than the divisor. Only the low ITERS
// quotient bits are produced.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load dividend/divisor and begin (ignored while busy)
//   dividend    : DVD_W-bit unsigned dividend
//   divisor     : DVS_W-bit unsigned divisor (non-zero)
//   busy        : an iteration happens at the next clock edge
//   done        : the next clock edge performs the final iteration
//   quotient    : quotient including the iteration in progress; it holds the
//                 final result in the cycle where done is high
// ----------------------------------------------------------------------------
module seq_udiv_restoring #(
    parameter int DVD_W = 20,
    parameter int DVS_W = 12,
    parameter int ITERS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [ITERS-1:0] quotient
);

    localparam int PRE_W = DVD_W - ITERS;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [DVS_W:0]   rem;
    logic [ITERS-1:0] dvd_lo;
    logic [DVS_W-1:0] dvs;
    logic [ITERS-1:0] q;
    logic [CNT_W-1:0] cnt;

    logic [DVS_W:0]   trial;
    logic             ge;
    logic [DVS_W:0]   rem_nxt;
    logic [ITERS-1:0] q_nxt;

    // Remainder stays below the divisor, so shifting in one bit fits DVS_W+1
    always_comb begin
        trial   = {rem[DVS_W-1:0], dvd_lo[ITERS-1]};
        ge      = (trial >= {1'b0, dvs});
        rem_nxt = ge ? (trial - {1'b0, dvs}) : trial;
        q_nxt   = {q[ITERS-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            dvd_lo <= '0;
            dvs    <= '0;
            q      <= '0;
            cnt    <= '0;
        end else if (start && (cnt == '0)) begin
            rem    <= {{(DVS_W + 1 - PRE_W){1'b0}}, dividend[DVD_W-1:ITERS]};
            dvd_lo <= dividend[ITERS-1:0];
            dvs    <= divisor;
            q      <= '0;
            cnt    <= CNT_W'(ITERS);
        end else if (cnt != '0) begin
            rem    <= rem_nxt;
            dvd_lo <= dvd_lo << 1;
            q      <= q_nxt;
            cnt    <= cnt - 1'b1;
        end
    end

    assign busy     = (cnt != '0);
    assign done     = (cnt == CNT_W'(1));
    assign quotient = q_nxt;

endmodule

// File: rtl/exp_scale_reduce.sv
// ----------------------------------------------------------------------------
// exp_scale_reduce
// Range reduction of an unsigned Q4.8 value x against the exp-scale table:
// finds k with scale[k] <= x and returns residual = x / scale[k] in Q4.8.
// Single-item FSM (IDLE -> SEARCH -> [DIV] -> DONE) around a restoring divider.
// Optional build macro EXP_SCALE_REDUCE_ROUND_EN: one extra divider iteration
// supplies a guard bit for round-half-up (clamped to all-ones on carry).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data = x (Q4.8)
//   out_valid/out_ready  : result handshake, outputs held until accepted
//   exp_int              : k
//   residual             : x / scale[k] (Q4.8)
//   under                : x below 1.0
//   sat                  : x at or above the saturated table entry
// ----------------------------------------------------------------------------
module exp_scale_reduce
    import exp_scale_pkg::*;
#(
    parameter int DATA_W = ES_DATA_W,
    parameter int FRAC_W = ES_FRAC_W,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  exp_int,
    output logic [DATA_W-1:0] residual,
    output logic              under,
    output logic              sat
);

`ifdef EXP_SCALE_REDUCE_ROUND_EN
    localparam int GUARD_W = 1;
`else
    localparam int GUARD_W = 0;
`endif
    localparam int DIV_ITERS = DATA_W + GUARD_W;
    localparam int DVD_W     = DATA_W + FRAC_W + GUARD_W;

    localparam logic [DATA_W-1:0] SC0 = DATA_W'(EXP_SCALE_0);
    localparam logic [DATA_W-1:0] SC1 = DATA_W'(EXP_SCALE_1);
    localparam logic [DATA_W-1:0] SC2 = DATA_W'(EXP_SCALE_2);
    localparam logic [DATA_W-1:0] SC3 = DATA_W'(EXP_SCALE_3);

    // Quotient to residual: drop the guard bit with half-up rounding, clamp on carry
    function automatic logic [DATA_W-1:0] round_q(input logic [DIV_ITERS-1:0] q);
`ifdef EXP_SCALE_REDUCE_ROUND_EN
        logic [DATA_W:0] s;
        s = {1'b0, q[DIV_ITERS-1:1]} + (DATA_W + 1)'(q[0]);
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
`else
        return q;
`endif
    endfunction

    es_state_t             state, state_nxt;
    logic [DATA_W-1:0]     x_reg;

    logic [IDX_W-1:0]      cls_k;
    logic                  cls_div;
    logic                  cls_sat;
    logic                  cls_under;
    logic [DATA_W-1:0]     cls_dvs;

    logic                  div_start;
    logic                  div_busy;
    logic                  div_done;
    logic [DIV_ITERS-1:0]  div_q;

    // Table search on the captured input
    always_comb begin
        cls_k     = '0;
        cls_div   = 1'b0;
        cls_sat   = 1'b0;
        cls_under = 1'b0;
        cls_dvs   = SC1;
        if (x_reg >= SC3) begin
            cls_k   = IDX_W'(3);
            cls_sat = 1'b1;
        end else if (x_reg >= SC2) begin
            cls_k   = IDX_W'(2);
            cls_div = 1'b1;
            cls_dvs = SC2;
        end else if (x_reg >= SC1) begin
            cls_k   = IDX_W'(1);
            cls_div = 1'b1;
            cls_dvs = SC1;
        end else if (x_reg < SC0) begin
            cls_under = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            ST_IDLE:   if (in_valid) state_nxt = ST_SEARCH;
            ST_SEARCH: begin
                div_start = cls_div;
                state_nxt = cls_div ? ST_DIV : ST_DONE;
            end
            ST_DIV:    if (div_busy && div_done) state_nxt = ST_DONE;
            ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Result registers: set in SEARCH, residual overwritten by the divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg    <= '0;
            exp_int  <= '0;
            residual <= '0;
            under    <= 1'b0;
            sat      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:   if (in_valid) x_reg <= in_data;
                ST_SEARCH: begin
                    exp_int  <= cls_k;
                    sat      <= cls_sat;
                    under    <= cls_under;
                    residual <= cls_sat ? SC0 : x_reg;
                end
                ST_DIV:    if (div_busy && div_done) residual <= round_q(div_q);
                default:   ;
            endcase
        end
    end

    // Held low while reset is asserted, even though the state decodes to IDLE
    assign in_ready  = rst_n && (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    seq_udiv_restoring #(
        .DVD_W (DVD_W),
        .DVS_W (DATA_W),
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({x_reg, {(FRAC_W + GUARD_W){1'b0}}}),
        .divisor  (cls_dvs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

endmodule

// File: tb/tb_exp_scale_reduce.sv
// ----------------------------------------------------------------------------
// tb_exp_scale_reduce
// Directed vectors with hand-computed results; a driver pushes the expected
// response into a queue at acceptance and a monitor pops and compares it when
// the result is transferred.
// ----------------------------------------------------------------------------
module tb_exp_scale_reduce;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  exp_int;
    logic [11:0] residual;
    logic        under;
    logic        sat;

`ifdef EXP_SCALE_REDUCE_ROUND_EN
    localparam int DIV_LAT = 15;
    localparam int R_400   = 12'h179;
    localparam int R_780   = 12'h104;
    localparam int R_7FE   = 12'h115;
`else
    localparam int DIV_LAT = 14;
    localparam int R_400   = 12'h178;
    localparam int R_780   = 12'h103;
    localparam int R_7FE   = 12'h114;
`endif

    typedef struct {
        int x;
        int k;
        int r;
        int u;
        int s;
        int lat;
        int t;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   nvec;
    int   nerr;
    bit   lat_checked;

    exp_scale_reduce dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_int   (exp_int),
        .residual  (residual),
        .under     (under),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: latency at first out_valid, payload at the transfer cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            lat_checked = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_out: out_valid=1 with no pending item, residual=0x%0h", residual);
            end else begin
                if (!lat_checked) begin
                    chk($sformatf("latency x=%0h", sb[0].x), cyc - sb[0].t, sb[0].lat);
                    lat_checked = 1'b1;
                end
                if (out_ready) begin
                    chk($sformatf("exp_int x=%0h", sb[0].x), int'(exp_int), sb[0].k);
                    chk($sformatf("residual x=%0h", sb[0].x), int'(residual), sb[0].r);
                    chk($sformatf("under x=%0h", sb[0].x), int'(under), sb[0].u);
                    chk($sformatf("sat x=%0h", sb[0].x), int'(sat), sb[0].s);
                    void'(sb.pop_front());
                    lat_checked = 1'b0;
                end
            end
        end
    end

    // Called just after a negedge; returns just after a later negedge
    task automatic send(input int x, input int k, input int r, input int u,
                        input int s, input int lat);
        exp_t e;
        bit   acc;
        acc      = 1'b0;
        in_data  = 12'(x);
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            if (in_ready) begin
                e = '{x: x, k: k, r: r, u: u, s: s, lat: lat, t: cyc};
                sb.push_back(e);
                acc = 1'b1;
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) chk($sformatf("accept_timeout x=%0h", x), 0, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic run(input int x, input int k, input int r, input int u,
                       input int s, input int lat);
        send(x, k, r, u, s, lat);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst in_ready", int'(in_ready), 0);
        chk("rst exp_int", int'(exp_int), 0);
        chk("rst residual", int'(residual), 0);
        chk("rst under", int'(under), 0);
        chk("rst sat", int'(sat), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle in_ready", int'(in_ready), 1);

        // x, k, residual, under, sat, latency
        run(12'h400, 1, R_400,  0, 0, DIV_LAT);
        run(12'h780, 2, R_780,  0, 0, DIV_LAT);
        run(12'h7FE, 2, R_7FE,  0, 0, DIV_LAT);
        run(12'h0C0, 0, 12'h0C0, 1, 0, 2);
        run(12'h000, 0, 12'h000, 1, 0, 2);
        run(12'hFFF, 3, 12'h100, 0, 1, 2);
        run(12'h7FF, 3, 12'h100, 0, 1, 2);
        run(12'h2B8, 1, 12'h100, 0, 0, DIV_LAT);
        run(12'h764, 2, 12'h100, 0, 0, DIV_LAT);
        run(12'h2B7, 0, 12'h2B7, 0, 0, 2);
        run(12'h100, 0, 12'h100, 0, 0, 2);

        // Backpressure: result held for 20 cycles, a new request is ignored
        out_ready = 1'b0;
        send(12'h400, 1, R_400, 0, 0, DIV_LAT);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp out_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                in_data  = 12'h0C0;
                in_valid = 1'b1;
            end
            chk("bp out_valid", int'(out_valid), 1);
            chk("bp in_ready", int'(in_ready), 0);
            chk("bp residual", int'(residual), R_400);
            chk("bp exp_int", int'(exp_int), 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        chk("bp in_ready_after", int'(in_ready), 1);
        repeat (4) @(negedge clk);
        chk("bp no_extra_out", int'(out_valid), 0);

        // Reset in the middle of a division drops the item
        send(12'h400, 1, R_400, 0, 0, DIV_LAT);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst in_ready", int'(in_ready), 0);
        chk("midrst residual", int'(residual), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst in_ready_after", int'(in_ready), 1);
        repeat (20) @(negedge clk);
        chk("midrst no_out", int'(out_valid), 0);
        run(12'h780, 2, R_780, 0, 0, DIV_LAT);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
